button_event_decoder: RTL and testbench
=======================================

# button_event_decoder

Converts the clean, synchronised button level from the debouncer into single-cycle user events: press, release, short press, long press and double click. Sits directly downstream of the synchroniser + debouncer pair; its input is the debouncer output level. All outputs are registered, so the block can drive control logic or an event FIFO directly.

## Interface
Parameters:
- LONG_CLKS, 50_000_000: consecutive high samples that make a long press; legal range ≥ 2.
- GAP_CLKS, 12_500_000: consecutive low samples after a short release within which a second press counts as a double click; legal range ≥ 2.
- CNT_W, $clog2(max(LONG_CLKS,GAP_CLKS)+1): hold/gap counter width; derived, not overridden.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_in  in  1  debounced button level, already synchronous to clk; 1 = pressed.
- press_pulse  out  1  one-cycle pulse on each sampled rising edge of btn_in.
- release_pulse  out  1  one-cycle pulse on each sampled falling edge of btn_in.
- short_press  out  1  one-cycle pulse: completed press shorter than LONG_CLKS, not part of a double click.
- long_press  out  1  one-cycle pulse when a hold reaches LONG_CLKS samples; the press is still in progress.
- double_click  out  1  one-cycle pulse on the release of the second short press.
- btn_level  out  1  registered copy of btn_in.

## Operation
- Edge detection: btn_q holds the previous sample. A rise is btn_in=1 with btn_q=0; a fall is btn_in=0 with btn_q=1.
- States:
  - IDLE
  - PRESSED
  - LONG_HELD
  - WAIT_GAP
  - SECOND_PRESS
- IDLE: on a rise, go to PRESSED, set cnt=1 and pulse press_pulse.
- PRESSED: while high, cnt increments.
  - When the sample reaching cnt==LONG_CLKS is high: pulse long_press and go to LONG_HELD.
  - On a fall before that: pulse release_pulse. Next state depends on the double-click configuration (see Configuration).
- LONG_HELD: on a fall, pulse release_pulse and go to IDLE. long_press never repeats within one hold.
- WAIT_GAP: cnt counts consecutive low samples.
  - On a rise before the gap expires: pulse press_pulse, set cnt=1 and go to SECOND_PRESS.
  - When the GAP_CLKS-th consecutive low sample is taken: pulse short_press and go to IDLE.
- SECOND_PRESS:
  - On a fall before LONG_CLKS: pulse release_pulse and double_click, then go to IDLE.
  - On reaching LONG_CLKS high samples: pulse long_press and go to LONG_HELD. The first press is discarded (no short_press, no double_click).
- Counters saturate at 2^CNT_W−1 and never wrap.
- Boundary rules:
  - A rise sampled on the same edge the gap would expire counts as a second press; gap expiry requires btn_in=0.
  - A release sampled on the LONG_CLKS-th edge (btn_in=0 there) is a short press.
- At most one of short_press / long_press / double_click is high in any cycle.

## Timing
- Reset (rst sampled high): state=IDLE, cnt=0, btn_q=0, all outputs 0.
  - Applies mid-operation: any press in progress is abandoned and no event is emitted.
  - If btn_in is high after reset deasserts, a press_pulse is generated on the first sampled edge.
- press_pulse / release_pulse: asserted from the edge that first samples the new level; high for exactly one cycle.
- long_press: asserted at edge N+LONG_CLKS−1, where N is the edge that sampled the rise.
- short_press (double-click enabled): asserted at edge R+GAP_CLKS−1, where R is the first low sample after release.
- double_click: coincides with the second release_pulse.
- btn_level: lags btn_in by one cycle.

## Configuration
- Macro BTN_DOUBLE_CLICK_EN.
- Defined: the full state machine above is built. short_press is delayed by the gap window.
- Undefined:
  - WAIT_GAP and SECOND_PRESS are not built.
  - From PRESSED, a fall emits short_press together with release_pulse on the same edge, then the FSM returns to IDLE.
  - double_click is tied to 0.
  - GAP_CLKS is ignored for CNT_W sizing.

## Structure
- Package btn_event_pkg holds:
  - typedef enum logic [2:0] btn_state_t with fixed encodings IDLE=0, PRESSED=1, LONG_HELD=2, WAIT_GAP=3, SECOND_PRESS=4;
  - an event-vector typedef for grouping the five pulses.
- One sub-module, edge_detect, registers btn_in into btn_q and produces the rise and fall strobes. The FSM and counter live in the top module.

## Test plan
All scenarios use LONG_CLKS=20 and GAP_CLKS=8.
- Hold high 5 cycles then low; macro defined → press_pulse, release_pulse, then short_press exactly 7 edges after the first low sample; double_click stays 0.
- Hold high 25 cycles → long_press at the 20th high edge, exactly once; release gives release_pulse only.
- High 4, low 3, high 4, low → two press_pulses, then double_click on the second release; short_press never asserts.
- High 4, low 7, rise on the 8th edge → treated as a second press, double_click on its release. Repeat with the rise on the 9th edge → short_press at the 8th low edge, then a fresh PRESSED sequence.
- rst asserted while in PRESSED at cnt=15 → all outputs 0 on the next cycle and no long_press. Macro undefined, high 5 then low → short_press on the same edge as release_pulse.

Source files
------------

// File: rtl/btn_event_pkg.sv
// Shared types for the button event decoder: FSM state encoding and the
// registered event-pulse vector.
package btn_event_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESSED      = 3'd1,
        LONG_HELD    = 3'd2,
        WAIT_GAP     = 3'd3,
        SECOND_PRESS = 3'd4
    } btn_state_t;

    typedef struct packed {
        logic press;
        logic rls;
        logic shrt;
        logic lng;
        logic dbl;
    } btn_events_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event_decoder_edge_detect.sv
// Registers the debounced button level and derives single-sample rise/fall
// strobes from the current sample and the previous one.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_btn_q,
    output logic o_rise,
    output logic o_fall
);

    logic r_btn_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_q <= 1'b0;
        end else begin
            r_btn_q <= i_btn;
        end
    end

    assign o_btn_q = r_btn_q;
    assign o_rise  = i_btn & ~r_btn_q;
    assign o_fall  = ~i_btn & r_btn_q;

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into registered one-cycle press/release/short/
// long/double-click events. Double-click support is built when BTN_DOUBLE_CLICK_EN is defined.
module button_event_decoder
    import btn_event_pkg::*;
#(
    parameter int unsigned LONG_CLKS = 50_000_000,
    parameter int unsigned GAP_CLKS  = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic btn_level
);

`ifdef BTN_DOUBLE_CLICK_EN
    localparam int unsigned CNT_W = $clog2(max_u(LONG_CLKS, GAP_CLKS) + 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CLKS - 1);
`else
    localparam int unsigned CNT_W = $clog2(LONG_CLKS + 1);
`endif
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CLKS - 1);

    if (LONG_CLKS < 2 || GAP_CLKS < 2) begin : g_bad_params
        $error("button_event_decoder: LONG_CLKS and GAP_CLKS must both be >= 2");
    end

    logic w_btn_q;
    logic w_rise;
    logic w_fall;

    edge_detect u_edge_detect (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_in),
        .o_btn_q (w_btn_q),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    btn_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    btn_events_t      r_evt, w_evt_nxt;

    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    // The cycle that samples the LONG_CLKS-th high level is the one where cnt still reads LONG_CLKS-1.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_evt_nxt   = '0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt     = PRESSED;
                    w_cnt_nxt       = CNT_W'(1);
                    w_evt_nxt.press = 1'b1;
                end
            end
            PRESSED: begin
                if (w_fall) begin
                    w_evt_nxt.rls = 1'b1;
`ifdef BTN_DOUBLE_CLICK_EN
                    w_state_nxt   = WAIT_GAP;
                    w_cnt_nxt     = CNT_W'(1);
`else
                    w_evt_nxt.shrt = 1'b1;
                    w_state_nxt    = IDLE;
                    w_cnt_nxt      = '0;
`endif
                end else if (btn_in && r_cnt == LONG_LAST) begin
                    w_evt_nxt.lng = 1'b1;
                    w_state_nxt   = LONG_HELD;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            LONG_HELD: begin
                if (w_fall) begin
                    w_evt_nxt.rls = 1'b1;
                    w_state_nxt   = IDLE;
                    w_cnt_nxt     = '0;
                end
            end
`ifdef BTN_DOUBLE_CLICK_EN
            WAIT_GAP: begin
                // A rise on the expiry edge wins: expiry needs a low sample.
                if (w_rise) begin
                    w_evt_nxt.press = 1'b1;
                    w_state_nxt     = SECOND_PRESS;
                    w_cnt_nxt       = CNT_W'(1);
                end else if (r_cnt == GAP_LAST) begin
                    w_evt_nxt.shrt = 1'b1;
                    w_state_nxt    = IDLE;
                    w_cnt_nxt      = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            SECOND_PRESS: begin
                if (w_fall) begin
                    w_evt_nxt.rls = 1'b1;
                    w_evt_nxt.dbl = 1'b1;
                    w_state_nxt   = IDLE;
                    w_cnt_nxt     = '0;
                end else if (btn_in && r_cnt == LONG_LAST) begin
                    w_evt_nxt.lng = 1'b1;
                    w_state_nxt   = LONG_HELD;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_evt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_evt   <= w_evt_nxt;
        end
    end

    assign press_pulse   = r_evt.press;
    assign release_pulse = r_evt.rls;
    assign short_press   = r_evt.shrt;
    assign long_press    = r_evt.lng;
    assign double_click  = r_evt.dbl;
    assign btn_level     = w_btn_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG_CLKS=20, GAP_CLKS=8; each
// step drives one sample and checks all six outputs one time unit after the edge.
module tb_button_event_decoder;

    localparam logic [4:0] EV_NONE  = 5'b00000;
    localparam logic [4:0] EV_PRESS = 5'b10000;
    localparam logic [4:0] EV_REL   = 5'b01000;
    localparam logic [4:0] EV_SHORT = 5'b00100;
    localparam logic [4:0] EV_LONG  = 5'b00010;
    localparam logic [4:0] EV_DBL   = 5'b00001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_in = 1'b0;
    logic press_pulse, release_pulse, short_press, long_press, double_click, btn_level;

    int n_checks = 0;
    int n_errors = 0;

    button_event_decoder #(
        .LONG_CLKS (20),
        .GAP_CLKS  (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_in),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_press   (short_press),
        .long_press    (long_press),
        .double_click  (double_click),
        .btn_level     (btn_level)
    );

    always #5 clk = ~clk;

    // Expected vector: {press, release, short, long, double, btn_level}.
    task automatic step(input logic b, input logic [4:0] ev, input string tag);
        logic [5:0] obs;
        logic [5:0] exp;
        btn_in = b;
        @(posedge clk);
        #1;
        exp = {ev, (rst ? 1'b0 : b)};
        obs = {press_pulse, release_pulse, short_press, long_press, double_click, btn_level};
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b (press,rel,short,long,dbl,level)", tag, obs, exp);
        end
    endtask

    task automatic steps(input logic b, input int n, input logic [4:0] ev, input string tag);
        for (int i = 0; i < n; i++) begin
            step(b, ev, tag);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, including a button already held during reset.
        step(1'b0, EV_NONE, "rst_idle");
        step(1'b1, EV_NONE, "rst_btn_high");
        rst = 1'b0;

        // Short press: 5 high samples then low; first high is the post-reset rise.
        step(1'b1, EV_PRESS, "a_press_after_reset");
        steps(1'b1, 4, EV_NONE, "a_hold");
`ifdef BTN_DOUBLE_CLICK_EN
        step(1'b0, EV_REL, "a_release");
        steps(1'b0, 6, EV_NONE, "a_gap");
        step(1'b0, EV_SHORT, "a_short_after_gap");
`else
        step(1'b0, EV_REL | EV_SHORT, "a_release_short");
`endif
        steps(1'b0, 2, EV_NONE, "a_idle");

        // Long press: 25 highs, long on the 20th high sample, once only.
        step(1'b1, EV_PRESS, "b_press");
        steps(1'b1, 18, EV_NONE, "b_hold");
        step(1'b1, EV_LONG, "b_long");
        steps(1'b1, 5, EV_NONE, "b_held_no_repeat");
        step(1'b0, EV_REL, "b_release");
        steps(1'b0, 9, EV_NONE, "b_no_short");

        // Release sampled on the LONG_CLKS-th edge is a short press.
        step(1'b1, EV_PRESS, "c_press");
        steps(1'b1, 18, EV_NONE, "c_hold");
`ifdef BTN_DOUBLE_CLICK_EN
        step(1'b0, EV_REL, "c_release_at_long_edge");
        steps(1'b0, 6, EV_NONE, "c_gap");
        step(1'b0, EV_SHORT, "c_short");
`else
        step(1'b0, EV_REL | EV_SHORT, "c_release_at_long_edge");
`endif
        steps(1'b0, 2, EV_NONE, "c_idle");

`ifdef BTN_DOUBLE_CLICK_EN
        // High 4, low 3, high 4, low: double click, no short.
        step(1'b1, EV_PRESS, "d_press1");
        steps(1'b1, 3, EV_NONE, "d_hold1");
        step(1'b0, EV_REL, "d_rel1");
        steps(1'b0, 2, EV_NONE, "d_gap");
        step(1'b1, EV_PRESS, "d_press2");
        steps(1'b1, 3, EV_NONE, "d_hold2");
        step(1'b0, EV_REL | EV_DBL, "d_double");
        steps(1'b0, 9, EV_NONE, "d_no_short");

        // Rise on the 8th gap edge still counts as a second press.
        step(1'b1, EV_PRESS, "e_press1");
        steps(1'b1, 3, EV_NONE, "e_hold1");
        step(1'b0, EV_REL, "e_rel1");
        steps(1'b0, 6, EV_NONE, "e_gap");
        step(1'b1, EV_PRESS, "e_press_on_expiry_edge");
        step(1'b1, EV_NONE, "e_hold2");
        step(1'b0, EV_REL | EV_DBL, "e_double");
        steps(1'b0, 9, EV_NONE, "e_idle");

        // Rise on the 9th edge: gap already expired, fresh press follows.
        step(1'b1, EV_PRESS, "f_press1");
        steps(1'b1, 3, EV_NONE, "f_hold1");
        step(1'b0, EV_REL, "f_rel1");
        steps(1'b0, 6, EV_NONE, "f_gap");
        step(1'b0, EV_SHORT, "f_short");
        step(1'b1, EV_PRESS, "f_fresh_press");
        step(1'b1, EV_NONE, "f_hold2");
        step(1'b0, EV_REL, "f_rel2");
        steps(1'b0, 6, EV_NONE, "f_gap2");
        step(1'b0, EV_SHORT, "f_short2");
        steps(1'b0, 2, EV_NONE, "f_idle");

        // Second press held long: first press discarded.
        step(1'b1, EV_PRESS, "g_press1");
        step(1'b1, EV_NONE, "g_hold1");
        step(1'b0, EV_REL, "g_rel1");
        step(1'b1, EV_PRESS, "g_press2");
        steps(1'b1, 18, EV_NONE, "g_hold2");
        step(1'b1, EV_LONG, "g_long");
        step(1'b1, EV_NONE, "g_held");
        step(1'b0, EV_REL, "g_release");
        steps(1'b0, 9, EV_NONE, "g_no_short_no_dbl");
`endif

        // Reset in PRESSED at cnt=15 abandons the press; held button re-presses.
        step(1'b1, EV_PRESS, "h_press");
        steps(1'b1, 14, EV_NONE, "h_hold");
        rst = 1'b1;
        step(1'b1, EV_NONE, "h_reset_mid_press");
        rst = 1'b0;
        step(1'b1, EV_PRESS, "h_repress_after_reset");
        steps(1'b1, 18, EV_NONE, "h_no_stale_long");
        step(1'b1, EV_LONG, "h_long");
        step(1'b0, EV_REL, "h_release");
        steps(1'b0, 9, EV_NONE, "h_idle");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
